// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the fetch stage: datapath width, reset PC,
// queue depth, and the {pc, inst} queue entry.
package inst_fetch_pkg;

  localparam int CPU_WIDTH = 32;

  typedef logic [CPU_WIDTH-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int    DEFAULT_QDEPTH   = 2;
  localparam word_t PC_STEP          = 32'h0000_0004;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  // Redirect targets may carry junk in the low bits; fetch is always word aligned.
  function automatic word_t align_pc(input word_t pc);
    return {pc[CPU_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory port, execute redirect, and the
// valid/ready handshake towards decode.
interface inst_fetch_if
  import inst_fetch_pkg::*;
  ;

  logic  redirect_en;
  word_t redirect_pc;
  word_t curr_pc;
  word_t inst;
  logic  if_valid;
  word_t if_inst;
  word_t if_pc;
  logic  if_ready;

  modport master (
    input  redirect_en,
    input  redirect_pc,
    input  inst,
    input  if_ready,
    output curr_pc,
    output if_valid,
    output if_inst,
    output if_pc
  );

  modport slave (
    output redirect_en,
    output redirect_pc,
    output inst,
    output if_ready,
    input  curr_pc,
    input  if_valid,
    input  if_inst,
    input  if_pc
  );

endinterface

// File: rtl/inst_fifo.sv
// In-order instruction queue holding {pc, inst} entries; synchronous flush
// clears occupancy and pointers, reset additionally zeroes the storage.
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QDEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction memory, and queues fetched words for decode with redirect flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter int    QDEPTH   = DEFAULT_QDEPTH
) (
  input logic         clk,
  input logic         rst_n,
  inst_fetch_if.master bus
);

  word_t        fetch_pc_q, fetch_pc_d;
  logic         push;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  logic         q_valid;
  fetch_entry_t q_wdata;
  fetch_entry_t q_rdata;

  assign q_valid = ~q_empty;

  // Redirect has priority: it suppresses both push and pop in its cycle.
  assign pop     = q_valid & bus.if_ready & ~bus.redirect_en;
  assign push    = ~bus.redirect_en & (~q_full | pop);
  assign q_wdata = '{pc: fetch_pc_q, inst: bus.inst};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_en) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  inst_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_en),
    .push  (push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.curr_pc  = fetch_pc_q;
  assign bus.if_valid = q_valid;
  assign bus.if_inst  = q_rdata.inst;
  assign bus.if_pc    = q_rdata.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, stall/fill, redirect,
// PC wrap and reset-over-redirect, against a hand-computed instruction memory.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory contents: a distinctive word derived from the address.
  function automatic word_t mem_word(input word_t a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign bus.inst = mem_word(bus.curr_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input word_t pc);
    check({tag, "_valid"}, word_t'(bus.if_valid), 32'd1);
    check({tag, "_pc"},    bus.if_pc,             pc);
    check({tag, "_inst"},  bus.if_inst,           mem_word(pc));
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.if_ready    = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_valid", word_t'(bus.if_valid), 32'd0);
    check("rst_inst",  bus.if_inst,           32'd0);
    check("rst_pc",    bus.if_pc,             32'd0);
    check("rst_curr",  bus.curr_pc,           32'd0);

    // Streaming with decode always ready
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head($sformatf("stream%0d", i), word_t'(4 * i));
    end

    // Stall after reset: queue fills with 0,4 and PC freezes at 8
    rst_n        = 1'b0;
    bus.if_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_head($sformatf("stall%0d", i), 32'h0);
    end
    check("stall_curr", bus.curr_pc, 32'h8);

    // Release: full queue pushes and pops together, PC keeps stepping
    bus.if_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_head($sformatf("drain%0d", i), word_t'(4 * i));
      check($sformatf("drain%0d_curr", i), bus.curr_pc, word_t'(4 * i + 8));
    end

    // Redirect with unaligned target while full and ready
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect_en = 1'b0;
    check("redir_valid", word_t'(bus.if_valid), 32'd0);
    check("redir_curr",  bus.curr_pc,           32'h0000_0100);
    tick();
    check_head("redir_head", 32'h0000_0100);

    // Redirect while stalled: flush wins over the stalled head
    bus.if_ready    = 1'b0;
    tick();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    tick();
    bus.redirect_en = 1'b0;
    bus.if_ready    = 1'b1;
    check("redir2_valid", word_t'(bus.if_valid), 32'd0);
    check("redir2_curr",  bus.curr_pc,           32'h0000_0040);
    tick();
    check_head("redir2_head", 32'h0000_0040);

    // PC wrap past the top of the address space
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_en = 1'b0;
    check("wrap_curr", bus.curr_pc, 32'hFFFF_FFF8);
    tick();
    check_head("wrap0", 32'hFFFF_FFF8);
    tick();
    check_head("wrap1", 32'hFFFF_FFFC);
    tick();
    check_head("wrap2", 32'h0000_0000);

    // Reset asserted together with a redirect: reset wins
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    rst_n           = 1'b0;
    tick();
    bus.redirect_en = 1'b0;
    check("rstredir_valid", word_t'(bus.if_valid), 32'd0);
    check("rstredir_curr",  bus.curr_pc,           32'd0);
    check("rstredir_pc",    bus.if_pc,             32'd0);
    check("rstredir_inst",  bus.if_inst,           32'd0);
    rst_n = 1'b1;
    tick();
    check_head("rstredir_head0", 32'h0);
    tick();
    check_head("rstredir_head1", 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the single-issue core. Owns the program counter, drives the fetch address into the combinational instruction memory, and captures the returned instruction word with its PC into a small in-order queue. Instructions are presented to the decode stage over a valid/ready handshake. A one-cycle redirect from execute (branch, jump or trap) flushes the queue and restarts fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset. Must be word aligned.
- `QDEPTH`, default 2: instruction queue entries. Power of two, ≥2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `redirect_en`, input, 1: restart fetch at `redirect_pc`; highest priority.
- `redirect_pc`, input, `CPU_WIDTH`: redirect target. Bits [1:0] are ignored and treated as 0.
- `curr_pc`, output, `CPU_WIDTH`: fetch address to instruction memory; equals `fetch_pc`, purely combinational.
- `inst`, input, `CPU_WIDTH`: instruction word returned combinationally for `curr_pc` in the same cycle.
- `if_valid`, output, 1: queue head holds a valid instruction.
- `if_inst`, output, `CPU_WIDTH`: instruction at queue head.
- `if_pc`, output, `CPU_WIDTH`: PC of `if_inst`.
- `if_ready`, input, 1: decode accepts the head this cycle.

## Operation
- State: `fetch_pc` register; queue storage of `QDEPTH` {pc, inst} entries; read and write pointers of log2(`QDEPTH`) bits each; occupancy `count` of log2(`QDEPTH`)+1 bits.
- `pop` = `if_valid & if_ready & ~redirect_en`.
- `push` = `~redirect_en & (count != QDEPTH | pop)`. A full queue accepts a push in the same cycle it pops.
- On `push`: write {`fetch_pc`, `inst`} at the write pointer, advance the write pointer, and set `fetch_pc` <= `fetch_pc` + 4. The add is modulo 2^`CPU_WIDTH`, so 32'hFFFF_FFFC wraps to 0.
- On `pop`: advance the read pointer.
- Occupancy: push only increments `count`; pop only decrements it; push and pop together leave it unchanged.
- Pointers wrap modulo `QDEPTH`.
- On `redirect_en`:
  - `count`, both pointers <= 0.
  - `fetch_pc` <= {`redirect_pc`[`CPU_WIDTH`-1:2], 2'b00}.
  - No push and no pop take effect that cycle, whatever the values of `if_ready` and `count`.
- Outputs:
  - `if_valid` = (`count` != 0).
  - `if_inst` and `if_pc` are read from the entry at the read pointer.
  - While `if_valid & ~if_ready`, `if_inst` and `if_pc` hold stable.
- Reset (`rst_n`=0 at an edge): `fetch_pc` <= `RESET_PC`; `count` and pointers <= 0; all queue entries <= 0. After reset, `if_valid`=0, `if_inst`=0, `if_pc`=0, and `curr_pc`=`RESET_PC`. Reset overrides `redirect_en` and any in-flight push or pop.

## Timing
- Fetch-to-decode latency is 1 cycle. An instruction addressed in cycle N is visible at the queue head in cycle N+1, provided the queue was empty.
- First edge with `rst_n`=1: `RESET_PC` is pushed; `if_valid`=1 from the following cycle.
- Redirect asserted in cycle N:
  - `if_valid`=0 in cycle N+1.
  - `curr_pc`=target in cycle N+1.
  - The target instruction is valid at the head in cycle N+2.
- Sustained throughput with `if_ready` held at 1: one instruction per cycle with no bubbles.
- Decode stalled: the queue fills to `QDEPTH`, then `fetch_pc` freezes. `curr_pc` stays at the next unfetched address.

## Structure
- Shared defines file: `CPU_WIDTH`, the default reset PC constant, and the instruction-queue depth constant.
- Sub-module `inst_fifo`: synchronous FIFO with `QDEPTH` entries, synchronous flush, and push/pop/full/empty signals. Entry data is {pc, inst}. `inst_fetch` keeps the PC register, push/pop control and redirect priority.

## Test plan
- Reset release with `RESET_PC`=0 and `if_ready`=1: `if_pc` must read 0, 4, 8, 12 on consecutive cycles from cycle 1, with `if_inst` equal to the memory contents at each address.
- Hold `if_ready`=0 for 5 cycles after reset: `count` saturates at 2; `curr_pc` stays at 8; `if_pc` holds 0. Release `if_ready`: 0, 4, 8 emerge in order with no loss or duplication.
- Redirect to 32'h0000_0103 while full and `if_ready`=1: next cycle `if_valid`=0 and `curr_pc`=32'h100; the cycle after, `if_pc`=32'h100.
- Simultaneous push and pop at full (`if_ready`=1, queue full): `count` stays 2 and PCs continue +4 per cycle.
- PC wrap: redirect to 32'hFFFF_FFF8: `if_pc` sequence FFFF_FFF8, FFFF_FFFC, 0.
- Reset asserted mid-stream during a redirect: next cycle `if_valid`=0 and `curr_pc`=`RESET_PC`. The redirect target is never fetched.
